// File: rtl/led_sequence_monitor.sv
// Passive observer for the flasher LED bus: decodes the lit count, follows the
// sweep direction, counts reversals and completed cycles, and latches violations.
module led_sequence_monitor #(
    parameter int  WIDTH     = 16,
    parameter int  CNT_W     = 8,
    parameter int  FLICK_WIN = 2,
    localparam int LC_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick,
    input  logic [WIDTH-1:0] led,
    output logic [LC_W-1:0]  lit_count,
    output logic [1:0]       dir,
    output logic             turn_pulse,
    output logic [LC_W-1:0]  turn_level,
    output logic [CNT_W-1:0] kickback_cnt,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             err_pattern,
    output logic             err_step,
    output logic             err_start
);

    localparam int AW = (FLICK_WIN > 0) ? $clog2(FLICK_WIN + 1) : 1;
    localparam logic signed [LC_W:0] STEP_MAX = (LC_W + 1)'(1);
    localparam logic [AW-1:0]        ARM_LOAD = AW'(FLICK_WIN);
    localparam logic [LC_W-1:0]      FULL     = LC_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_e;

    function automatic logic [LC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [LC_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + LC_W'(v[i]);
        end
        return n;
    endfunction

    // A thermometer code has no set bit above a clear bit, so v & (v+1) is zero.
    function automatic logic is_thermo(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] x;
        x = {1'b0, v};
        return (x & (x + 1'b1)) == '0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [WIDTH-1:0] led_p0_q;
    logic             flick_p0_q;
    logic             vld_p0_q;

    state_e           state_q, state_d;
    logic [LC_W-1:0]  lit_count_q, lit_count_d;
    logic             turn_pulse_q, turn_pulse_d;
    logic [LC_W-1:0]  turn_level_q, turn_level_d;
    logic [CNT_W-1:0] kickback_q, kickback_d;
    logic             cycle_done_q, cycle_done_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic             err_pattern_q, err_pattern_d;
    logic             err_step_q, err_step_d;
    logic             err_start_q, err_start_d;
    logic [AW-1:0]    arm_q, arm_d;

    logic [LC_W-1:0]      cnt_p1;
    logic signed [LC_W:0] diff_p1;
    logic                 rise_p1, fall_p1;

    assign cnt_p1  = popcount(led_p0_q);
    assign diff_p1 = $signed({1'b0, cnt_p1}) - $signed({1'b0, lit_count_q});
    assign rise_p1 = !diff_p1[LC_W] && (diff_p1 != '0);
    assign fall_p1 = diff_p1[LC_W];

    // Stage p1: classify the captured sample against the previous count
    always_comb begin
        state_d       = state_q;
        lit_count_d   = lit_count_q;
        turn_pulse_d  = 1'b0;
        turn_level_d  = turn_level_q;
        kickback_d    = kickback_q;
        cycle_done_d  = 1'b0;
        cycle_d       = cycle_q;
        err_pattern_d = err_pattern_q;
        err_step_d    = err_step_q;
        err_start_d   = err_start_q;
        arm_d         = arm_q;

        if (vld_p0_q) begin
            lit_count_d = cnt_p1;
            if (!is_thermo(led_p0_q)) err_pattern_d = 1'b1;
            if (diff_p1 > STEP_MAX || diff_p1 < -STEP_MAX) err_step_d = 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (rise_p1) begin
                        state_d = S_UP;
                        arm_d   = '0;
                        if (arm_q == '0) err_start_d = 1'b1;
                    end else if (flick_p0_q) begin
                        arm_d = ARM_LOAD;
                    end else if (arm_q != '0) begin
                        arm_d = arm_q - 1'b1;
                    end
                end
                S_UP: begin
                    if (fall_p1) begin
                        state_d      = S_DOWN;
                        turn_pulse_d = 1'b1;
                        turn_level_d = lit_count_q;
                        if (lit_count_q < FULL) kickback_d = sat_inc(kickback_q);
                    end
                end
                S_DOWN: begin
                    if (rise_p1) begin
                        state_d      = S_UP;
                        turn_pulse_d = 1'b1;
                        turn_level_d = lit_count_q;
                    end else if (cnt_p1 == '0) begin
                        state_d      = S_IDLE;
                        cycle_done_d = 1'b1;
                        cycle_d      = sat_inc(cycle_q);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Stage p0: capture bus and flick; stage p1 registers the decoded results
    always_ff @(posedge clk) begin
        if (rst) begin
            led_p0_q      <= '0;
            flick_p0_q    <= 1'b0;
            vld_p0_q      <= 1'b0;
            state_q       <= S_IDLE;
            lit_count_q   <= '0;
            turn_pulse_q  <= 1'b0;
            turn_level_q  <= '0;
            kickback_q    <= '0;
            cycle_done_q  <= 1'b0;
            cycle_q       <= '0;
            err_pattern_q <= 1'b0;
            err_step_q    <= 1'b0;
            err_start_q   <= 1'b0;
            arm_q         <= '0;
        end else begin
            led_p0_q      <= led;
            flick_p0_q    <= flick;
            vld_p0_q      <= 1'b1;
            state_q       <= state_d;
            lit_count_q   <= lit_count_d;
            turn_pulse_q  <= turn_pulse_d;
            turn_level_q  <= turn_level_d;
            kickback_q    <= kickback_d;
            cycle_done_q  <= cycle_done_d;
            cycle_q       <= cycle_d;
            err_pattern_q <= err_pattern_d;
            err_step_q    <= err_step_d;
            err_start_q   <= err_start_d;
            arm_q         <= arm_d;
        end
    end

    assign lit_count    = lit_count_q;
    assign dir          = state_q;
    assign turn_pulse   = turn_pulse_q;
    assign turn_level   = turn_level_q;
    assign kickback_cnt = kickback_q;
    assign cycle_done   = cycle_done_q;
    assign cycle_cnt    = cycle_q;
    assign err_pattern  = err_pattern_q;
    assign err_step     = err_step_q;
    assign err_start    = err_start_q;

endmodule

// File: tb/tb_led_sequence_monitor.sv
// Randomized scoreboard bench for led_sequence_monitor: a sample-level reference
// model queues the expected outputs, and a negedge monitor compares them.
module tb_led_sequence_monitor;

    localparam int WIDTH     = 16;
    localparam int CNT_W     = 4;
    localparam int FLICK_WIN = 2;
    localparam int LC_W      = 5;
    localparam int KMAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flick = 1'b0;
    logic [WIDTH-1:0] led = '0;
    logic [LC_W-1:0]  lit_count;
    logic [1:0]       dir;
    logic             turn_pulse;
    logic [LC_W-1:0]  turn_level;
    logic [CNT_W-1:0] kickback_cnt;
    logic             cycle_done;
    logic [CNT_W-1:0] cycle_cnt;
    logic             err_pattern, err_step, err_start;

    led_sequence_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .FLICK_WIN(FLICK_WIN)) dut (
        .clk(clk), .rst(rst), .flick(flick), .led(led),
        .lit_count(lit_count), .dir(dir), .turn_pulse(turn_pulse),
        .turn_level(turn_level), .kickback_cnt(kickback_cnt),
        .cycle_done(cycle_done), .cycle_cnt(cycle_cnt),
        .err_pattern(err_pattern), .err_step(err_step), .err_start(err_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [LC_W-1:0]  lit;
        logic [1:0]       dir;
        logic             tp;
        logic [LC_W-1:0]  tl;
        logic [CNT_W-1:0] kick;
        logic             cd;
        logic [CNT_W-1:0] cyc;
        logic             ep, es, est;
    } exp_t;

    exp_t sb_q[$];
    int   ecount = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) ecount <= ecount + 1;

    // Reference model: mode 0 idle, 1 rising, 2 falling; flick armed by sample index
    int m_mode, m_prev, m_tl, m_kick, m_cyc, m_s, m_last_flick;
    bit m_ep, m_es, m_est;

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_tl = 0; m_kick = 0; m_cyc = 0;
        m_ep = 0; m_es = 0; m_est = 0; m_last_flick = -1000;
    endtask

    function automatic exp_t zero_exp(input int due);
        exp_t e;
        e.due = due; e.lit = '0; e.dir = '0; e.tp = 0; e.tl = '0; e.kick = '0;
        e.cd = 0; e.cyc = '0; e.ep = 0; e.es = 0; e.est = 0;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] therm(input int c);
        logic [WIDTH:0] t;
        t = (17'd1 << c) - 17'd1;
        return t[WIDTH-1:0];
    endfunction

    task automatic model_step(input logic [WIDTH-1:0] v, input logic f, input int due, output exp_t e);
        int  cnt, d;
        bit  tp, cd;
        cnt = $countones(v);
        d   = cnt - m_prev;
        tp  = 0;
        cd  = 0;
        if (v != therm(cnt)) m_ep = 1;
        if (d > 1 || d < -1) m_es = 1;
        case (m_mode)
            0: begin
                if (d > 0) begin
                    if (m_s - m_last_flick > FLICK_WIN) m_est = 1;
                    m_mode = 1;
                    m_last_flick = -1000;
                end else if (f) begin
                    m_last_flick = m_s;
                end
            end
            1: if (d < 0) begin
                m_mode = 2; tp = 1; m_tl = m_prev;
                if (m_prev < WIDTH && m_kick < KMAX) m_kick++;
            end
            default: begin
                if (d > 0) begin
                    m_mode = 1; tp = 1; m_tl = m_prev;
                end else if (cnt == 0) begin
                    m_mode = 0; cd = 1;
                    if (m_cyc < KMAX) m_cyc++;
                end
            end
        endcase
        m_prev = cnt;
        m_s++;
        e.due = due; e.lit = LC_W'(cnt); e.dir = 2'(m_mode); e.tp = tp; e.tl = LC_W'(m_tl);
        e.kick = CNT_W'(m_kick); e.cd = cd; e.cyc = CNT_W'(m_cyc);
        e.ep = m_ep; e.es = m_es; e.est = m_est;
    endtask

    // Drive one sample just after an edge; its result is due two edges later.
    task automatic step(input logic r, input logic [WIDTH-1:0] v, input logic f);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; led = v; flick = f;
        if (r) begin
            model_reset();
            if (sb_q.size() > 0 && sb_q[$].due == ecount + 1) void'(sb_q.pop_back());
            sb_q.push_back(zero_exp(ecount + 1));
            sb_q.push_back(zero_exp(ecount + 2));
        end else begin
            model_step(v, f, ecount + 2, e);
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= ecount) begin
            exp_t e;
            e = sb_q.pop_front();
            total++;
            if (e.due != ecount || lit_count !== e.lit || dir !== e.dir || turn_pulse !== e.tp ||
                turn_level !== e.tl || kickback_cnt !== e.kick || cycle_done !== e.cd ||
                cycle_cnt !== e.cyc || err_pattern !== e.ep || err_step !== e.es ||
                err_start !== e.est) begin
                bad++;
                $display("FAIL outputs@edge%0d: got lit=%0d dir=%0d tp=%0b tl=%0d kick=%0d cd=%0b cyc=%0d err(p,s,st)=%b%b%b want lit=%0d dir=%0d tp=%0b tl=%0d kick=%0d cd=%0b cyc=%0d err(p,s,st)=%b%b%b due=%0d",
                         ecount, lit_count, dir, turn_pulse, turn_level, kickback_cnt, cycle_done,
                         cycle_cnt, err_pattern, err_step, err_start, e.lit, e.dir, e.tp, e.tl,
                         e.kick, e.cd, e.cyc, e.ep, e.es, e.est, e.due);
            end
        end
    end

    initial begin
        int c, top, idle_wait;
        bit wup;
        model_reset();
        m_s = 0;

        // Reset, then a quiet bus
        step(1, '0, 0);
        step(1, '0, 0);
        repeat (20) step(0, '0, 0);

        // Clean full sweep after a flick
        step(0, '0, 1);
        for (int k = 1; k <= 16; k++) step(0, therm(k), 0);
        for (int k = 15; k >= 0; k--) step(0, therm(k), 0);

        // Kickback at 6, full sweep, unarmed start, armed start
        step(0, '0, 1);
        for (int k = 1; k <= 6; k++) step(0, therm(k), 0);
        for (int k = 5; k >= 0; k--) step(0, therm(k), 0);
        step(0, '0, 1);
        for (int k = 1; k <= 16; k++) step(0, therm(k), 0);
        for (int k = 15; k >= 0; k--) step(0, therm(k), 0);
        repeat (3) step(0, '0, 0);
        step(0, 16'h0001, 0);
        step(0, 16'h0000, 0);
        step(1, '0, 0);
        step(0, '0, 1);
        step(0, '0, 0);
        step(0, 16'h0001, 0);

        // Illegal pattern and a multi-step jump, then reset mid-sweep at 10
        step(0, 16'h0003, 0);
        step(0, 16'h0005, 0);
        step(0, therm(3), 0);
        step(0, therm(7), 0);
        for (int k = 8; k <= 10; k++) step(0, therm(k), 0);
        step(1, '0, 0);
        step(0, '0, 0);
        step(0, '0, 1);
        for (int k = 1; k <= 3; k++) step(0, therm(k), 0);
        for (int k = 2; k >= 0; k--) step(0, therm(k), 0);

        // Random sweeps; error and reset injection in the second part
        c = 0; top = 5; wup = 1; idle_wait = 2;
        for (int i = 0; i < 1500; i++) begin
            bit              ef;
            int              r;
            logic            f;
            logic [WIDTH-1:0] v;
            ef = (i >= 500);
            r  = $urandom_range(0, 99);
            if (ef && r == 0) begin
                step(1, '0, 0);
                c = 0; wup = 1; top = $urandom_range(1, 16); idle_wait = $urandom_range(0, 4);
                continue;
            end
            if (c == 0 && idle_wait > 0) idle_wait--;
            else if (r < 10) begin end
            else if (wup) begin
                if (c < top) c++;
                else begin wup = 0; c--; end
            end else if (r < 20 && c < 16) begin
                wup = 1; top = $urandom_range(c + 1, 16); c++;
            end else c--;
            v = therm(c);
            if (ef && r >= 95) v = WIDTH'($urandom);
            else if (ef && r >= 92) begin
                c = $urandom_range(0, 16);
                v = therm(c);
                wup = (c < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
                top = 16;
            end
            if (c == 0 && !wup) begin
                wup = 1; top = $urandom_range(1, 16); idle_wait = $urandom_range(0, 4);
            end
            f = (c == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            step(0, v, f);
        end

        repeat (4) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb_q.size());
        end
        total++;
        if (total < 12) begin
            bad++;
            $display("FAIL coverage: got %0d comparisons, want at least 12", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
